// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch/sequencing stage that sits in front of the decode-only control unit.
// It owns the program counter and the instruction register, and it fetches
// one instruction at a time from instruction memory over a req/ack handshake.
// It presents the opcode and operand to decode, then advances or branches
// the PC once execute reports completion. Only one instruction is in flight.
//
// Ports:
//   clk         : single clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset
//   imem_req    : fetch request to instruction memory (high for the whole WAIT)
//   imem_addr   : fetch address, equal to pc
//   imem_ack    : memory response valid, imem_rdata is sampled in this cycle
//   imem_rdata  : fetched instruction word
//   stall       : holds the fetch before a request is issued
//   ir_load     : from control unit, enables IR capture at ack
//   pc_load     : from control unit, sampled at instr_done, selects branch
//   instr_done  : execute-side completion of the current instruction
//   opcode      : top 4 bits of IR
//   operand     : remaining low bits of IR
//   pc          : current program counter
//   instr_valid : IR holds a decodable instruction (EXEC state)
//   halted      : halt opcode has been reached
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               ir_load,
  input  logic               pc_load,
  input  logic               instr_done,
  output logic [3:0]         opcode,
  output logic [INSTR_W-5:0] operand,
  output logic [ADDR_W-1:0]  pc,
  output logic               instr_valid,
  output logic               halted
);

  // State encoding kept as plain constants so older tools and scripts that
  // peek at the state register still understand it.
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [3:0]        HALT_OPCODE = 4'hF;
  localparam logic [ADDR_W-1:0] PC_INIT     = ADDR_W'(RESET_PC);

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;

  logic               w_fetchGo;
  logic               w_capture;
  logic               w_refetch;
  logic               w_incoming_halt;
  logic [ADDR_W-1:0]  w_pcNext;
  logic [INSTR_W-5:0] w_operand;

  // Handshake decode. An ack is honoured only in WAIT, so a response that
  // arrives in FETCH (e.g. a late ack after reset) is simply dropped.
  assign w_fetchGo       = (r_state == FETCH) && !stall;
  assign w_capture       = (r_state == WAIT) && imem_ack && ir_load;
  assign w_refetch       = (r_state == WAIT) && imem_ack && !ir_load;
  assign w_incoming_halt = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);

  assign w_operand = r_ir[INSTR_W-5:0];

  // Branch target is the low ADDR_W bits of the operand; the sequential path
  // relies on natural ADDR_W-bit wraparound (all-ones rolls to zero).
  assign w_pcNext = pc_load ? w_operand[ADDR_W-1:0] : (r_pc + ADDR_W'(1));

  // Sequencer. Reset wins in every state, which also abandons an
  // outstanding request because imem_req is derived from the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= PC_INIT;
      r_ir    <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_fetchGo) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_capture) begin
            r_ir    <= imem_rdata;
            r_state <= w_incoming_halt ? HALT : EXEC;
          end else if (w_refetch) begin
            r_state <= FETCH;
          end
        end
        EXEC: begin
          if (instr_done) begin
            r_pc    <= w_pcNext;
            r_state <= FETCH;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they are glitch-free
  // with respect to the inputs and change only at clock edges.
  assign imem_req    = (r_state == WAIT);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr_valid = (r_state == EXEC);
  assign halted      = (r_state == HALT);
  assign opcode      = r_ir[INSTR_W-1 -: 4];
  assign operand     = w_operand;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A small behavioural model tracks
// the architectural PC, IR and halt flag at the level of whole instructions.
// After every clock the bench compares the DUT outputs against what that
// model says must be visible.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int ADDR_W   = 8;
  localparam int INSTR_W  = 16;
  localparam int RESET_PC = 0;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               ir_load;
  logic               pc_load;
  logic               instr_done;
  logic [3:0]         opcode;
  logic [INSTR_W-5:0] operand;
  logic [ADDR_W-1:0]  pc;
  logic               instr_valid;
  logic               halted;

  int assertCount = 0;
  int failCount   = 0;

  logic [INSTR_W-1:0] memImage [256];
  int                 modelPc;
  logic [INSTR_W-1:0] modelIr;
  bit                 modelHalted;

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .ir_load    (ir_load),
    .pc_load    (pc_load),
    .instr_done (instr_done),
    .opcode     (opcode),
    .operand    (operand),
    .pc         (pc),
    .instr_valid(instr_valid),
    .halted     (halted)
  );

  // 10-unit clock; inputs change and outputs are sampled on the falling edge
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch with tag and values
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock: inputs set beforehand hit the next rising edge
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  // Compare every visible output against the model
  task automatic checkState(input string tag, input bit expReq, input bit expValid);
    checkOutput({tag, ".req"}, 32'(imem_req), 32'(expReq));
    if (expReq) checkOutput({tag, ".addr"}, 32'(imem_addr), 32'(modelPc));
    checkOutput({tag, ".pc"}, 32'(pc), 32'(modelPc));
    checkOutput({tag, ".valid"}, 32'(instr_valid), 32'(expValid));
    checkOutput({tag, ".halted"}, 32'(halted), 32'(modelHalted));
    checkOutput({tag, ".opcode"}, 32'(opcode), 32'(modelIr[15:12]));
    checkOutput({tag, ".operand"}, 32'(operand), 32'(modelIr[11:0]));
  endtask

  task automatic doReset(input string tag);
    rst_n      = 1'b0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    instr_done = 1'b0;
    applyStimulus();
    rst_n       = 1'b1;
    modelPc     = RESET_PC;
    modelIr     = '0;
    modelHalted = 1'b0;
    checkState(tag, 1'b0, 1'b0);
  endtask

  // One fetch: optional stall, request, (latency-1) wait cycles, then ack.
  // Spurious instr_done / stall pulses during WAIT must have no effect.
  task automatic fetchOne(input logic [INSTR_W-1:0] word, input int latency,
                          input bit irLoad, input int stallCycles,
                          input bit noisy, input string tag);
    for (int i = 0; i < stallCycles; i++) begin
      stall = 1'b1;
      applyStimulus();
      checkState({tag, ".stall"}, 1'b0, 1'b0);
    end
    stall = 1'b0;
    applyStimulus();
    checkState({tag, ".issue"}, 1'b1, 1'b0);
    for (int i = 1; i < latency; i++) begin
      stall      = noisy && (i == 1);
      instr_done = noisy;
      pc_load    = noisy;
      applyStimulus();
      checkState({tag, ".wait"}, 1'b1, 1'b0);
    end
    stall      = 1'b0;
    instr_done = 1'b0;
    pc_load    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    ir_load    = irLoad;
    applyStimulus();
    imem_ack   = 1'b0;
    ir_load    = 1'b0;
    imem_rdata = 16'($urandom);
    if (irLoad) begin
      modelIr = word;
      if (word[15:12] == 4'hF) modelHalted = 1'b1;
    end
    checkState({tag, ".ack"}, 1'b0, irLoad && !modelHalted);
  endtask

  // Execute phase: wait doneDelay cycles in EXEC, then complete
  task automatic execOne(input int doneDelay, input bit pcLoad,
                         input bit stallWithDone, input string tag);
    for (int i = 0; i < doneDelay; i++) begin
      pc_load = 1'($urandom_range(0, 1));
      applyStimulus();
      checkState({tag, ".exec"}, 1'b0, 1'b1);
    end
    pc_load    = pcLoad;
    instr_done = 1'b1;
    stall      = stallWithDone;
    applyStimulus();
    instr_done = 1'b0;
    pc_load    = 1'b0;
    modelPc    = pcLoad ? int'(modelIr[7:0]) : (modelPc + 1) % 256;
    checkState({tag, ".done"}, 1'b0, 1'b0);
  endtask

  // Run the three-instruction straight-line prologue from reset
  task automatic runPrologue(input string tag);
    fetchOne(memImage[0], 1, 1'b1, 0, 1'b0, {tag, ".i0"});
    execOne(0, 1'b0, 1'b0, {tag, ".i0"});
    fetchOne(memImage[1], 1, 1'b1, 0, 1'b0, {tag, ".i1"});
    execOne(0, 1'b0, 1'b0, {tag, ".i1"});
    fetchOne(memImage[2], 1, 1'b1, 0, 1'b0, {tag, ".i2"});
    execOne(0, 1'b0, 1'b0, {tag, ".i2"});
  endtask

  initial begin
    // Random program image, halt opcode kept out so random runs continue
    for (int a = 0; a < 256; a++) begin
      memImage[a] = 16'($urandom);
      if (memImage[a][15:12] == 4'hF) memImage[a][15:12] = 4'h7;
    end
    memImage[0] = 16'h1005;
    memImage[1] = 16'h0007;
    memImage[3] = 16'h20A0;

    // Straight line then taken branch to 0xA0
    doReset("rst0");
    runPrologue("line");
    fetchOne(memImage[3], 1, 1'b1, 0, 1'b0, "br");
    execOne(0, 1'b1, 1'b0, "br");
    fetchOne(memImage[8'hA0], 2, 1'b1, 0, 1'b0, "atA0");
    execOne(1, 1'b0, 1'b0, "atA0");

    // Same program, branch not taken -> 0x04
    doReset("rst1");
    runPrologue("line2");
    fetchOne(memImage[3], 1, 1'b1, 0, 1'b0, "nobr");
    execOne(0, 1'b0, 1'b0, "nobr");
    fetchOne(memImage[4], 1, 1'b1, 0, 1'b0, "at04");
    execOne(0, 1'b0, 1'b0, "at04");

    // Branch to 0xFF, slow ack with noise, wrap to 0x00, stall with done
    fetchOne(16'h20FF, 1, 1'b1, 0, 1'b0, "toFF");
    execOne(0, 1'b1, 1'b0, "toFF");
    fetchOne(memImage[8'hFF], 6, 1'b1, 0, 1'b1, "slowFF");
    execOne(2, 1'b0, 1'b1, "wrap");
    fetchOne(memImage[0], 1, 1'b1, 2, 1'b0, "at00");
    execOne(0, 1'b0, 1'b0, "at00");

    // ir_load low at ack: no capture, refetch same pc, then capture
    fetchOne(16'h3456, 2, 1'b0, 0, 1'b0, "noload");
    fetchOne(16'h3456, 1, 1'b1, 0, 1'b0, "retry");
    execOne(0, 1'b0, 1'b0, "retry");

    // Halt: frozen for 20 cycles despite done/stall/pc_load noise
    fetchOne(16'hF000, 1, 1'b1, 0, 1'b0, "halt");
    for (int i = 0; i < 20; i++) begin
      instr_done = 1'($urandom_range(0, 1));
      stall      = 1'($urandom_range(0, 1));
      pc_load    = 1'($urandom_range(0, 1));
      applyStimulus();
      checkState("halted", 1'b0, 1'b0);
    end
    doReset("rstHalt");

    // Reset in the middle of WAIT, then a late ack must be ignored
    fetchOne(memImage[0], 1, 1'b1, 0, 1'b0, "preW");
    execOne(0, 1'b0, 1'b0, "preW");
    stall = 1'b0;
    applyStimulus();
    checkState("midW.issue", 1'b1, 1'b0);
    rst_n = 1'b0;
    applyStimulus();
    rst_n   = 1'b1;
    stall   = 1'b1;
    modelPc = RESET_PC;
    modelIr = '0;
    checkState("midW.rst", 1'b0, 1'b0);
    imem_ack   = 1'b1;
    ir_load    = 1'b1;
    imem_rdata = 16'h1234;
    applyStimulus();
    imem_ack = 1'b0;
    ir_load  = 1'b0;
    checkState("midW.late", 1'b0, 1'b0);

    // Randomized run against the model
    for (int n = 0; n < 40; n++) begin
      automatic int lat    = $urandom_range(1, 4);
      automatic bit irLd   = ($urandom_range(0, 3) != 0);
      automatic int stl    = $urandom_range(0, 2);
      automatic bit noisy  = 1'($urandom_range(0, 1));
      fetchOne(memImage[modelPc], lat, irLd, stl, noisy, $sformatf("rnd%0d", n));
      if (irLd) begin
        execOne($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
